// File: rtl/btn_conditioner.sv
// Per-button input conditioner: 2-flop synchronizer, stability-counter debounce,
// registered level plus press/release strobes, optional auto-repeat on held buttons.
module btn_conditioner #(
    parameter int unsigned          NUM_BTN         = 4,
    parameter int unsigned          DEBOUNCE_CYCLES = 500000,
    parameter int unsigned          CNT_WIDTH       = 20,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK     = '0,
    parameter int unsigned          REPEAT_DELAY    = 25000000,
    parameter int unsigned          REPEAT_RATE     = 5000000,
    parameter int unsigned          RPT_WIDTH       = 25
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam logic [CNT_WIDTH-1:0] DB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_WIDTH-1:0] DELAY_LAST = RPT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [RPT_WIDTH-1:0] RATE_LAST  = RPT_WIDTH'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RATE  = 2'd2
    } rpt_state_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic                 s1;
        logic                 s2;
        logic                 stable;
        logic                 stable_nxt;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] cnt_nxt;
        logic                 press_evt;
        logic                 rel_evt;
        rpt_state_t           state;
        rpt_state_t           state_nxt;
        logic [RPT_WIDTH-1:0] rcnt;
        logic [RPT_WIDTH-1:0] rcnt_nxt;
        logic                 rpt_fire;
        logic                 press_q;
        logic                 rel_q;

        // Debounce: any sample agreeing with the accepted state restarts the count.
        always_comb begin
            stable_nxt = stable;
            cnt_nxt    = '0;
            press_evt  = 1'b0;
            rel_evt    = 1'b0;
            if (s2 != stable) begin
                if (cnt == DB_LAST) begin
                    stable_nxt = s2;
                    press_evt  = s2;
                    rel_evt    = ~s2;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end

        // Auto-repeat next state; an accepted release overrides a coincident repeat.
        always_comb begin
            state_nxt = state;
            rcnt_nxt  = rcnt;
            rpt_fire  = 1'b0;
            case (state)
                RPT_IDLE: begin
                    if (press_evt && REPEAT_MASK[i]) begin
                        state_nxt = RPT_DELAY;
                        rcnt_nxt  = '0;
                    end
                end
                RPT_DELAY: begin
                    if (rcnt == DELAY_LAST) begin
                        rpt_fire  = 1'b1;
                        rcnt_nxt  = '0;
                        state_nxt = RPT_RATE;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                RPT_RATE: begin
                    if (rcnt == RATE_LAST) begin
                        rpt_fire = 1'b1;
                        rcnt_nxt = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RPT_IDLE;
                    rcnt_nxt  = '0;
                end
            endcase
            if (rel_evt) begin
                state_nxt = RPT_IDLE;
                rcnt_nxt  = '0;
                rpt_fire  = 1'b0;
            end
        end

        always_ff @(posedge MCLK or posedge reset) begin
            if (reset) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                stable  <= 1'b0;
                cnt     <= '0;
                state   <= RPT_IDLE;
                rcnt    <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                s1      <= btn_raw[i];
                s2      <= s1;
                stable  <= stable_nxt;
                cnt     <= cnt_nxt;
                state   <= state_nxt;
                rcnt    <= rcnt_nxt;
                press_q <= press_evt | rpt_fire;
                rel_q   <= rel_evt;
            end
        end

        assign btn_level[i]   = stable;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: debounce, glitch, press/release, auto-repeat, reset.
module tb_btn_conditioner;

    logic       MCLK = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] raw;
        logic [7:0] n;
        logic [3:0] mid;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
    } vec_t;

    vec_t tbl[$];

    btn_conditioner #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (3),
        .REPEAT_MASK     (4'b0100),
        .REPEAT_DELAY    (8),
        .REPEAT_RATE     (4),
        .RPT_WIDTH       (4)
    ) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] raw, input logic [7:0] n, input logic [3:0] mid,
                       input logic [3:0] lvl, input logic [3:0] pr, input logic [3:0] rl);
        vec_t v;
        v.raw   = raw;
        v.n     = n;
        v.mid   = mid;
        v.level = lvl;
        v.press = pr;
        v.rel   = rl;
        tbl.push_back(v);
    endtask

    // Hold raw for n edges; intermediate edges expect a quiet level, the last edge the row result.
    task automatic run_row(input vec_t v, input string tag);
        for (int c = 1; c <= int'(v.n); c++) begin
            btn_raw = v.raw;
            @(posedge MCLK);
            @(negedge MCLK);
            if (c == int'(v.n)) begin
                check($sformatf("%s.level", tag), btn_level, v.level);
                check($sformatf("%s.press", tag), btn_press, v.press);
                check($sformatf("%s.release", tag), btn_release, v.rel);
            end else begin
                check($sformatf("%s.e%0d.level", tag, c), btn_level, v.mid);
                check($sformatf("%s.e%0d.press", tag, c), btn_press, 4'b0000);
                check($sformatf("%s.e%0d.release", tag, c), btn_release, 4'b0000);
            end
        end
    endtask

    task automatic row(input string tag, input logic [3:0] raw, input logic [7:0] n,
                       input logic [3:0] mid, input logic [3:0] lvl,
                       input logic [3:0] pr, input logic [3:0] rl);
        vec_t v;
        v.raw   = raw;
        v.n     = n;
        v.mid   = mid;
        v.level = lvl;
        v.press = pr;
        v.rel   = rl;
        run_row(v, tag);
    endtask

    task automatic check_cleared(input string tag);
        check($sformatf("%s.level", tag), btn_level, 4'b0000);
        check($sformatf("%s.press", tag), btn_press, 4'b0000);
        check($sformatf("%s.release", tag), btn_release, 4'b0000);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 4'b0000;
        @(negedge MCLK);
        @(negedge MCLK);
        check_cleared("reset");
        reset = 1'b0;

        // Press on bit 2 accepted at edge E, then repeats at +8 and every 4 cycles.
        add(4'b0100, 8'd6,  4'b0000, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 8'd8,  4'b0100, 4'b0100, 4'b0100, 4'b0000);
        for (int k = 0; k < 5; k++)
            add(4'b0100, 8'd4, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 8'd2,  4'b0100, 4'b0100, 4'b0000, 4'b0000);
        // Raw falls at E+31; repeat at E+32 still fires, release at E+36 wins over repeat.
        add(4'b0000, 8'd1,  4'b0100, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0000, 8'd1,  4'b0100, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0000, 8'd4,  4'b0100, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0000, 8'd10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Bounce on bit 1, then stable high.
        for (int k = 0; k < 3; k++) begin
            add(4'b0010, 8'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
            add(4'b0000, 8'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        add(4'b0010, 8'd6,  4'b0000, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0010, 8'd2,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
        // Press and release bit 0 while bit 1 held.
        add(4'b0011, 8'd6,  4'b0010, 4'b0011, 4'b0001, 4'b0000);
        add(4'b0010, 8'd6,  4'b0011, 4'b0010, 4'b0000, 4'b0001);
        add(4'b0010, 8'd3,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
        // 3-cycle glitch on bit 3 rejected.
        add(4'b1010, 8'd3,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 8'd8,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
        // 4-cycle pulse on bit 3 is just long enough to be accepted.
        add(4'b1010, 8'd4,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 8'd1,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 8'd1,  4'b0010, 4'b1010, 4'b1000, 4'b0000);
        add(4'b0010, 8'd4,  4'b1010, 4'b0010, 4'b0000, 4'b1000);
        add(4'b0000, 8'd6,  4'b0010, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0000, 8'd3,  4'b0000, 4'b0000, 4'b0000, 4'b0000);

        for (int r = 0; r < tbl.size(); r++)
            run_row(tbl[r], $sformatf("row%0d", r));

        // Reset mid-debounce (count at 2), held button re-accepted 6 edges after release.
        row("dbpre", 4'b0001, 8'd4, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b1;
        #1;
        check_cleared("db_rst");
        @(posedge MCLK);
        @(negedge MCLK);
        reset = 1'b0;
        row("db_reacc", 4'b0001, 8'd6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

        // Reset mid-repeat on bit 2.
        row("rp_acc",  4'b0101, 8'd6, 4'b0001, 4'b0101, 4'b0100, 4'b0000);
        row("rp_first", 4'b0101, 8'd8, 4'b0101, 4'b0101, 4'b0100, 4'b0000);
        row("rp_hold", 4'b0101, 8'd2, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        reset = 1'b1;
        #1;
        check_cleared("rp_rst");
        @(posedge MCLK);
        @(negedge MCLK);
        check_cleared("rp_rst_held");
        reset = 1'b0;
        row("rp_reacc", 4'b0101, 8'd6, 4'b0000, 4'b0101, 4'b0101, 4'b0000);
        row("rp_wait", 4'b0101, 8'd7, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        row("rp_again", 4'b0101, 8'd1, 4'b0101, 4'b0101, 4'b0100, 4'b0000);
        row("rp_fall", 4'b0000, 8'd3, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
        row("rp_last", 4'b0000, 8'd1, 4'b0101, 4'b0101, 4'b0100, 4'b0000);
        row("rp_rel", 4'b0000, 8'd2, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
        row("rp_quiet", 4'b0000, 8'd10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Upstream input stage between the raw Basys2 push-buttons and top_adder_accumulator. Synchronizes each asynchronous button to MCLK, debounces it with a per-button stability counter, and produces a clean level plus single-cycle press/release strobes. Optional per-button auto-repeat on held buttons. The accumulator consumes btn_press, so one physical push yields exactly one load/add/reset event.

Parameters:
NUM_BTN, 4, number of independent button channels
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a change (>=1; sims use 4)
CNT_WIDTH, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1
REPEAT_MASK, 4'b0000, bit i=1 enables auto-repeat on channel i
REPEAT_DELAY, 25000000, held cycles after press before first repeat strobe (>=1)
REPEAT_RATE, 5000000, cycles between subsequent repeat strobes (>=1)
RPT_WIDTH, 25, repeat counter width; must hold max(REPEAT_DELAY,REPEAT_RATE)-1

Ports:
MCLK  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
btn_raw  input  NUM_BTN  raw asynchronous button inputs, 1 = pressed
btn_level  output  NUM_BTN  debounced button state
btn_press  output  NUM_BTN  1-cycle strobe on accepted press, or repeat strobe
btn_release  output  NUM_BTN  1-cycle strobe on accepted release

Behaviour:
- Reset: sync flops, stable state, debounce counters, repeat counters/state all 0; btn_level, btn_press, btn_release = 0. Outputs fully registered.
- Channels fully independent; identical logic per bit.
- Synchronizer: two flops, s1<=btn_raw[i], s2<=s1. No logic on s1.
- Debounce, each edge:
  - s2 == stable: cnt<=0.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0.
  - else: cnt<=cnt+1.
- Any single-sample match with stable during counting restarts count (glitch rejection). Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Latency: raw change sampled at edge k -> btn_level changes at edge k+1+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=4, that is 5 edges after first sample.
- btn_press[i] asserted for exactly the cycle in which btn_level[i] first reads 1 (registered alongside stable 0->1). btn_release[i] likewise for 1->0. Never both in one cycle on one channel.
- Auto-repeat (REPEAT_MASK[i]=1), states per channel:
  - IDLE: on accepted press -> DELAY, rcnt<=0.
  - DELAY: rcnt increments. When rcnt == REPEAT_DELAY-1: pulse btn_press, rcnt<=0, -> RATE.
  - RATE: rcnt increments. At REPEAT_RATE-1: pulse btn_press, rcnt<=0, stay in RATE.
  - Accepted release in any state -> IDLE, rcnt<=0, no further strobes. Release takes priority over a repeat strobe in the same cycle.
- REPEAT_MASK[i]=0: repeat FSM held in IDLE.
- Button held through reset deassertion: seen as press after DEBOUNCE_CYCLES+2 edges (stable reset to 0).
- Reset asserted mid-count or mid-repeat: immediate clear, no strobe emitted.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then hold btn_raw=4'b0100 -> btn_level[2] rises 5 edges after first sample edge; btn_press=4'b0100 for exactly 1 cycle; other bits 0.
- Bounce: btn_raw[1] toggles 1,0,1,0 every edge for 6 edges, then stable 1 -> no strobe during bouncing; single press strobe 5 edges after the final stable 1 is sampled.
- Release after accepted press on bit 0 -> btn_release[0] 1 cycle, 5 edges after raw falls; btn_level[0]=0; no btn_press.
- Glitch: 3-cycle high pulse on btn_raw[3] -> btn_level and all strobes remain 0.
- Auto-repeat: REPEAT_MASK=4'b0100, REPEAT_DELAY=8, REPEAT_RATE=4. Hold bit 2 for 30 cycles past acceptance -> strobes at acceptance, +8, +12, +16, +20, +24, +28. After release -> btn_release only, no more presses.
- Assert reset for 1 cycle mid-debounce (cnt=2) and mid-repeat -> all outputs 0 immediately; held button re-accepted 6 edges after reset drops.
